// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle RV32I control FSM with memory handshake.
// Ports: clk, rst_n, instr, Zero/LT/LTU flags, mem_ready in;
//   mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
//   ALUSrcA/B, ALUOp, ResultSrc, ImmSrc, instr_done, fault, state out.
module mc_ctrl_unit #(
   parameter bit          FULL_BRANCH = 1'b1,
   parameter int unsigned MAX_WAIT    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        Zero,
   input  logic        LT,
   input  logic        LTU,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [1:0]  ResultSrc,
   output logic [2:0]  ImmSrc,
   output logic        instr_done,
   output logic [1:0]  fault,
   output logic [3:0]  state
);

   localparam int unsigned WW =
      (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0] WLAST =
      WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALWB    = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   state_t        cur;
   state_t        nxt;
   logic [WW-1:0] wcnt;
   logic [1:0]    fault_q;

   logic [6:0] op;
   logic [2:0] f3;
   logic       is_ld, is_st, is_op, is_opi, is_br;
   logic       is_jal, is_jalr, is_lui, is_auipc;
   logic       br_ok, taken;
   logic       mem_st, mem_st_n, tmo, ill;
   logic       unused_instr;

   logic mreq, irw, pcw, rgw, mw, done;

   assign op = instr[6:0];
   assign f3 = instr[14:12];
   assign unused_instr = ^{instr[31:15], instr[11:7]};

   assign is_ld    = (op == 7'b0000011);
   assign is_st    = (op == 7'b0100011);
   assign is_op    = (op == 7'b0110011);
   assign is_opi   = (op == 7'b0010011);
   assign is_br    = (op == 7'b1100011);
   assign is_jal   = (op == 7'b1101111);
   assign is_jalr  = (op == 7'b1100111);
   assign is_lui   = (op == 7'b0110111);
   assign is_auipc = (op == 7'b0010111);

   // 010/011 never encode a branch; 1xx only with the full set
   assign br_ok = (f3[2:1] != 2'b01) && (FULL_BRANCH || !f3[2]);

   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000:  taken = Zero;
         3'b001:  taken = !Zero;
         3'b100:  taken = LT;
         3'b101:  taken = !LT;
         3'b110:  taken = LTU;
         3'b111:  taken = !LTU;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      ImmSrc = 3'b000;
      unique case (1'b1)
         is_st:            ImmSrc = 3'b001;
         is_br:            ImmSrc = 3'b010;
         is_jal:           ImmSrc = 3'b011;
         is_lui, is_auipc: ImmSrc = 3'b100;
         default:          ImmSrc = 3'b000;
      endcase
   end

   assign mem_st = (cur == S_FETCH) || (cur == S_MEMREAD) ||
                   (cur == S_MEMWRITE);
   assign mem_st_n = (nxt == S_FETCH) || (nxt == S_MEMREAD) ||
                     (nxt == S_MEMWRITE);

   // a ready on the last allowed cycle still completes the access
   assign tmo = (MAX_WAIT > 0) && mem_st && !mem_ready &&
                (wcnt == WLAST);

   always_comb begin
      nxt       = cur;
      ill       = 1'b0;
      mreq      = 1'b0;
      irw       = 1'b0;
      pcw       = 1'b0;
      rgw       = 1'b0;
      mw        = 1'b0;
      done      = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ResultSrc = 2'b00;
      case (cur)
         S_FETCH: begin
            mreq      = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (mem_ready) begin
               irw = 1'b1;
               pcw = 1'b1;
               nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            unique case (1'b1)
               is_ld, is_st: nxt = S_MEMADR;
               is_op:        nxt = S_EXECR;
               is_opi:       nxt = S_EXECI;
               is_jal:       nxt = S_JAL;
               is_jalr:      nxt = S_JALR;
               is_lui:       nxt = S_LUI;
               is_auipc:     nxt = S_ALUWB;
               is_br: begin
                  if (br_ok) begin
                     nxt = S_BRANCH;
                  end else begin
                     nxt = S_TRAP;
                     ill = 1'b1;
                  end
               end
               default: begin
                  nxt = S_TRAP;
                  ill = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            nxt = instr[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mreq   = 1'b1;
            AdrSrc = 1'b1;
            if (mem_ready) nxt = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            rgw       = 1'b1;
            done      = 1'b1;
            nxt       = S_FETCH;
         end
         S_MEMWRITE: begin
            mreq   = 1'b1;
            AdrSrc = 1'b1;
            mw     = 1'b1;
            if (mem_ready) begin
               done = 1'b1;
               nxt  = S_FETCH;
            end
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            nxt     = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            nxt     = S_ALUWB;
         end
         S_ALUWB: begin
            rgw  = 1'b1;
            done = 1'b1;
            nxt  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            pcw     = taken;
            done    = 1'b1;
            nxt     = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pcw     = 1'b1;
            nxt     = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pcw       = 1'b1;
            nxt       = S_JALWB;
         end
         S_JALWB: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            rgw       = 1'b1;
            done      = 1'b1;
            nxt       = S_FETCH;
         end
         S_LUI: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
            nxt     = S_ALUWB;
         end
         S_TRAP:  nxt = S_TRAP;
         default: nxt = S_TRAP;
      endcase
      if (tmo) nxt = S_TRAP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= S_FETCH;
         fault_q <= 2'b00;
         wcnt    <= '0;
      end else begin
         cur     <= nxt;
         fault_q <= fault_q | {tmo, ill};
         if (mem_st_n && (nxt != cur)) begin
            wcnt <= '0;
         end else if ((MAX_WAIT > 0) && mem_st && !mem_ready) begin
            wcnt <= wcnt + WW'(1);
         end
      end
   end

   // strobes are held low for the whole reset window
   assign mem_req    = mreq & rst_n;
   assign IRWrite    = irw  & rst_n;
   assign PCWrite    = pcw  & rst_n;
   assign RegWrite   = rgw  & rst_n;
   assign MemWrite   = mw   & rst_n;
   assign instr_done = done & rst_n;
   assign fault      = fault_q;
   assign state      = cur;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb_mc_ctrl_unit: directed stimulus with a per-cycle scoreboard.
// u0: full branch set, MAX_WAIT=4; u1: beq/bne only, no timeout.
module tb_mc_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        Zero, LT, LTU, mem_ready;

   logic       mreq0, adr0, irw0, pcw0, rgw0, mw0, done0;
   logic [1:0] a0, b0, op0, res0, flt0;
   logic [2:0] imm0;
   logic [3:0] st0;
   logic       mreq1, adr1, irw1, pcw1, rgw1, mw1, done1;
   logic [1:0] a1, b1, op1, res1, flt1;
   logic [2:0] imm1;
   logic [3:0] st1;

   always #5 clk = ~clk;

   mc_ctrl_unit #(.FULL_BRANCH(1'b1), .MAX_WAIT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .instr(instr),
      .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
      .mem_req(mreq0), .AdrSrc(adr0), .IRWrite(irw0),
      .PCWrite(pcw0), .RegWrite(rgw0), .MemWrite(mw0),
      .ALUSrcA(a0), .ALUSrcB(b0), .ALUOp(op0),
      .ResultSrc(res0), .ImmSrc(imm0), .instr_done(done0),
      .fault(flt0), .state(st0)
   );

   mc_ctrl_unit #(.FULL_BRANCH(1'b0), .MAX_WAIT(0)) u1 (
      .clk(clk), .rst_n(rst_n), .instr(instr),
      .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
      .mem_req(mreq1), .AdrSrc(adr1), .IRWrite(irw1),
      .PCWrite(pcw1), .RegWrite(rgw1), .MemWrite(mw1),
      .ALUSrcA(a1), .ALUSrcB(b1), .ALUOp(op1),
      .ResultSrc(res1), .ImmSrc(imm1), .instr_done(done1),
      .fault(flt1), .state(st1)
   );

   // {state, mem_req,IRW,PCW,RegW,MemW,done, AdrSrc,A,B,Op,Res, Imm, fault}
   logic [23:0] act0, act1;
   assign act0 = {st0, mreq0, irw0, pcw0, rgw0, mw0, done0,
                  adr0, a0, b0, op0, res0, imm0, flt0};
   assign act1 = {st1, mreq1, irw1, pcw1, rgw1, mw1, done1,
                  adr1, a1, b1, op1, res1, imm1, flt1};

   typedef struct {
      logic        d;
      logic [23:0] v;
      string       t;
   } exp_t;

   exp_t        q[$];
   exp_t        me;
   logic [23:0] ma;
   int          n_checks = 0;
   int          n_errors = 0;
   logic        dsel;
   logic [2:0]  eimm;
   logic [1:0]  efault;
   string       tag;

   // mux selects per state: AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc
   function automatic logic [23:0] mk(input logic [3:0] st,
                                      input logic [5:0] sb);
      logic [8:0] mx;
      case (st)
         4'd0:    mx = 9'b0_00_10_00_10;
         4'd1:    mx = 9'b0_01_01_00_00;
         4'd2:    mx = 9'b0_10_01_00_00;
         4'd3:    mx = 9'b1_00_00_00_00;
         4'd4:    mx = 9'b0_00_00_00_01;
         4'd5:    mx = 9'b1_00_00_00_00;
         4'd6:    mx = 9'b0_10_00_10_00;
         4'd7:    mx = 9'b0_10_01_10_00;
         4'd9:    mx = 9'b0_10_00_01_00;
         4'd10:   mx = 9'b0_01_10_00_00;
         4'd11:   mx = 9'b0_10_01_00_10;
         4'd12:   mx = 9'b0_01_10_00_10;
         4'd13:   mx = 9'b0_11_01_00_00;
         default: mx = 9'b0_00_00_00_00;
      endcase
      return {st, sb, mx, eimm, efault};
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         me = q.pop_front();
         ma = me.d ? act1 : act0;
         n_checks++;
         if (ma !== me.v) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got %h want %h",
                     me.t, me.d, $time, ma, me.v);
         end
      end
   end

   task automatic cyc(input logic [3:0] st, input logic [5:0] sb);
      exp_t e;
      e.d = dsel;
      e.v = mk(st, sb);
      e.t = tag;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      efault    = 2'b00;
      cyc(4'd0, 6'b000000);
      cyc(4'd0, 6'b000000);
      rst_n = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] w, input logic [2:0] im);
      instr     = w;
      eimm      = im;
      mem_ready = 1'b1;
      cyc(4'd0, 6'b111000);
   endtask

   initial begin
      rst_n = 1'b0; instr = 32'h0; Zero = 1'b0; LT = 1'b0;
      LTU = 1'b0; mem_ready = 1'b1; dsel = 1'b0;
      eimm = 3'b000; efault = 2'b00; tag = "reset";
      @(posedge clk);
      #1;
      do_reset();

      tag = "addi";
      fetch(32'h00500093, 3'b000);
      cyc(4'd1, 6'b0); cyc(4'd7, 6'b0); cyc(4'd8, 6'b000101);
      tag = "add";
      fetch(32'h00108133, 3'b000);
      cyc(4'd1, 6'b0); cyc(4'd6, 6'b0); cyc(4'd8, 6'b000101);

      tag = "lw_stall";
      fetch(32'h00002183, 3'b000);
      cyc(4'd1, 6'b0); cyc(4'd2, 6'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc(4'd3, 6'b100000);
      mem_ready = 1'b1;
      cyc(4'd3, 6'b100000); cyc(4'd4, 6'b000101);

      tag = "sw_stall";
      fetch(32'h00302023, 3'b001);
      cyc(4'd1, 6'b0); cyc(4'd2, 6'b0);
      mem_ready = 1'b0;
      cyc(4'd5, 6'b100010);
      mem_ready = 1'b1;
      cyc(4'd5, 6'b100011);

      tag = "beq_t";
      Zero = 1'b1;
      fetch(32'h00000063, 3'b010);
      cyc(4'd1, 6'b0); cyc(4'd9, 6'b001001);
      tag = "bne_nt";
      fetch(32'h00001063, 3'b010);
      cyc(4'd1, 6'b0); cyc(4'd9, 6'b000001);
      Zero = 1'b0;
      tag = "bltu_nt";
      fetch(32'h00006063, 3'b010);
      cyc(4'd1, 6'b0); cyc(4'd9, 6'b000001);
      tag = "bltu_t";
      LTU = 1'b1;
      fetch(32'h00006063, 3'b010);
      cyc(4'd1, 6'b0); cyc(4'd9, 6'b001001);
      LTU = 1'b0;
      tag = "bge_t";
      fetch(32'h00005063, 3'b010);
      cyc(4'd1, 6'b0); cyc(4'd9, 6'b001001);
      tag = "blt_t";
      LT = 1'b1;
      fetch(32'h00004063, 3'b010);
      cyc(4'd1, 6'b0); cyc(4'd9, 6'b001001);
      LT = 1'b0;

      tag = "jalr";
      fetch(32'h000280E7, 3'b000);
      cyc(4'd1, 6'b0); cyc(4'd11, 6'b001000); cyc(4'd12, 6'b000101);
      tag = "jal";
      fetch(32'h000000EF, 3'b011);
      cyc(4'd1, 6'b0); cyc(4'd10, 6'b001000); cyc(4'd8, 6'b000101);
      tag = "lui";
      fetch(32'h000010B7, 3'b100);
      cyc(4'd1, 6'b0); cyc(4'd13, 6'b0); cyc(4'd8, 6'b000101);
      tag = "auipc";
      fetch(32'h00000097, 3'b100);
      cyc(4'd1, 6'b0); cyc(4'd8, 6'b000101);

      tag = "br_f3_010";
      fetch(32'h00002063, 3'b010);
      cyc(4'd1, 6'b0);
      efault = 2'b01;
      cyc(4'd14, 6'b0); cyc(4'd14, 6'b0);
      tag = "rst_trap1";
      do_reset();

      tag = "illegal";
      fetch(32'h00000000, 3'b000);
      cyc(4'd1, 6'b0);
      efault = 2'b01;
      for (int i = 0; i < 3; i++) cyc(4'd14, 6'b0);
      tag = "rst_trap2";
      rst_n  = 1'b0;
      efault = 2'b00;
      cyc(4'd0, 6'b0);
      rst_n = 1'b1;

      tag = "tmo_fetch";
      instr = 32'h00500093;
      eimm = 3'b000;
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) cyc(4'd0, 6'b100000);
      efault = 2'b10;
      cyc(4'd14, 6'b0); cyc(4'd14, 6'b0);
      do_reset();

      tag = "tmo_ready4";
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc(4'd0, 6'b100000);
      mem_ready = 1'b1;
      cyc(4'd0, 6'b111000);
      cyc(4'd1, 6'b0); cyc(4'd7, 6'b0); cyc(4'd8, 6'b000101);

      tag = "tmo_memread";
      fetch(32'h00002183, 3'b000);
      cyc(4'd1, 6'b0); cyc(4'd2, 6'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) cyc(4'd3, 6'b100000);
      efault = 2'b10;
      cyc(4'd14, 6'b0);

      dsel = 1'b1;
      tag = "fb0_reset";
      do_reset();
      tag = "fb0_bltu";
      fetch(32'h00006063, 3'b010);
      cyc(4'd1, 6'b0);
      efault = 2'b01;
      cyc(4'd14, 6'b0); cyc(4'd14, 6'b0);
      do_reset();
      tag = "fb0_beq";
      Zero = 1'b1;
      fetch(32'h00000063, 3'b010);
      cyc(4'd1, 6'b0); cyc(4'd9, 6'b001001);
      Zero = 1'b0;
      tag = "fb0_nowait";
      mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) cyc(4'd0, 6'b100000);
      mem_ready = 1'b1;
      cyc(4'd0, 6'b111000);
      cyc(4'd1, 6'b0);

      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multi-cycle RV32I control unit: the sequenced successor to the single-cycle decoder. It steps each instruction through a Moore FSM and drives the shared-datapath muxes, register-file and memory strobes. It handshakes with a variable-latency unified memory and raises sticky faults for illegal encodings and bus timeouts. It sits between the instruction register, ALU flags and the multi-cycle datapath.

## Interface
- FULL_BRANCH, 1: 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq/bne only, funct3 1xx is illegal.
- MAX_WAIT, 0: maximum cycles `mem_req` may wait for `mem_ready`; 0 = unlimited.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  IR contents; valid from DECODE onward.
- Zero, LT, LTU  in  1 each  ALU flags: equal, signed less-than, unsigned less-than.
- mem_ready  in  1  memory accepts a write or returns read data this cycle.
- mem_req  out  1  memory access request.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite, PCWrite, RegWrite, MemWrite  out  1 each  write strobes.
- ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- ALUOp  out  2  00 add, 01 compare (subtract), 10 funct-decoded.
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALUResult.
- ImmSrc  out  3  I 000, S 001, B 010, J 011, U 100. Combinational from `instr[6:0]` in every state.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- fault  out  2  sticky: bit0 illegal instruction, bit1 bus timeout.
- state  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALWB 12, LUI 13, TRAP 14.
- FETCH
  - Drives mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - On mem_ready: IRWrite=1 and PCWrite=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE
  - Drives ALUSrcA=01, ALUSrcB=01, ALUOp=00; oldPC+imm lands in ALUOut.
  - Next state by opcode: load 0000011 and store 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; AUIPC 0010111 → ALUWB; anything else → TRAP with fault[0] set.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Load → MEMREAD, store → MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1, → FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 for the whole state. Memory commits on the mem_ready cycle; then instr_done=1 and → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1, → FETCH.
- BRANCH
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = taken, where taken is: funct3 000 Zero, 001 !Zero, 100 LT, 101 !LT, 110 LTU, 111 !LTU.
  - instr_done=1, → FETCH.
  - funct3 010/011, and 1xx when FULL_BRANCH=0, are detected in DECODE → TRAP.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, → ALUWB (writes oldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1, → JALWB.
- JALWB: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1, instr_done=1, → FETCH.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00, → ALUWB.
- TRAP: all strobes 0; absorbing until reset.
- Outputs not listed for a state are 0.
- Bus timeout (MAX_WAIT>0)
  - A wait counter of width $clog2(MAX_WAIT+1) clears on entry to any mem_req state and increments each cycle mem_ready=0.
  - Counter reaching MAX_WAIT with mem_ready=0 → TRAP, fault[1] set. A mem_ready on that same cycle wins: no fault.

## Timing
- Reset (rst_n low)
  - state=FETCH, fault=00, wait counter 0.
  - mem_req, IRWrite, PCWrite, RegWrite, MemWrite and instr_done are forced 0; mux selects show FETCH values.
  - First mem_req is on the first clock after rst_n deasserts.
- Reset mid-instruction aborts immediately; no strobe fires after rst_n falls.
- CPI with mem_ready tied high: load 5, store 4, R/I-ALU 4, branch 3, JAL 4, JALR 4, LUI 4, AUIPC 3. Each memory stall adds one cycle per mem_ready=0 cycle.
- All outputs are combinational from state, except PCWrite in BRANCH (from flags) and the handshake strobes gated by mem_ready in FETCH.

## Test plan
- mem_ready=1; program addi x1,x0,5 then add x2,x1,x1 → RegWrite pulses at cycles 4 and 8, instr_done twice, fault=00.
- lw with mem_ready low for 3 cycles in MEMREAD → MEMREAD held 4 cycles, RegWrite once in MEMWB, total 8 cycles.
- beq with Zero=1, then bltu with LTU=0 → PCWrite=1 in the first BRANCH, 0 in the second; FULL_BRANCH=0 bltu → TRAP, fault=01.
- jalr x1,0(x5) → PCWrite in JALR with ResultSrc=10, then RegWrite in JALWB with ALUSrcA=01, ALUSrcB=10.
- MAX_WAIT=4, mem_ready held 0 in FETCH → TRAP after 4 cycles, fault=10. Repeat with mem_ready on the 4th cycle → no fault.
- Opcode 0000000 → TRAP after DECODE, fault=01 sticky; rst_n pulse mid-TRAP → state=FETCH, fault=00, strobes 0.
